gcd_ctrl: RTL
=============

# gcd_ctrl

Control FSM for the subtractive GCD datapath. It accepts an operand pair via a valid/ready handshake and drives the datapath's mux selects and register enables. It iterates on the datapath status flags until the B register is zero, then presents the datapath's registered result via a valid/ready handshake. Together with the existing datapath it forms the complete GCD unit.

## Interface
Parameters:
- CNT_W, 16, width of the iteration counter (present only with GCD_CTRL_CYCLE_CNT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operand pair on datapath a/b inputs is valid
- in_ready  out  1  controller can accept operands
- out_valid  out  1  datapath res holds the final GCD
- out_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE
- beq0  in  1  datapath flag: breg == 0
- agtb  in  1  datapath flag: areg >= breg (note: greater-or-equal)
- sel_a  out  2  A mux select: 00 load a, 01 areg-breg, 10 breg, 11 zero
- sel_b  out  2  B mux select: 00 load b, 01 areg, 10 breg, 11 zero
- en_a  out  1  areg enable
- en_b  out  1  breg enable
- cycles  out  CNT_W  CALC-cycle count of last/current job (GCD_CTRL_CYCLE_CNT_EN only)

## Operation
- States: IDLE, CALC, DONE. Encoding is free; the state register is synchronously reset to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: sel_a=00, sel_b=00, en_a=en_b=1 in the same cycle (Mealy); next state CALC.
  - Else en_a=en_b=0.
- CALC (in_ready=0), evaluated on current flags, priority order:
  - beq0=1: en_a=en_b=0; next DONE.
  - agtb=1: subtract; sel_a=01, en_a=1, en_b=0; stay CALC.
  - else: swap; sel_a=10, sel_b=01, en_a=en_b=1; stay CALC.
- DONE:
  - out_valid=1; en_a=en_b=0, so areg and res stay frozen.
  - On out_ready: next IDLE.
  - in_ready=0 in DONE. A new job is accepted only from IDLE.
- Unused selects when the corresponding enable is 0 drive 00. Outputs are combinational from state, in_valid, beq0 and agtb; no combinational path from out_ready to any datapath control.
- Zero operands are legal: (0,0) gives 0; (x,0) gives x; (0,x) swaps once, then gives x.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, en_a=en_b=0, sel_a=sel_b=00, cycles=0.
- Load handshake at edge E0 → areg/breg loaded at E0; CALC cycles 1..N. Cycle N sees beq0=1.
- The datapath's res register samples areg at the edge ending cycle N. out_valid rises in cycle N+1 with res already correct; no extra drain state.
- Latency from handshake to out_valid = N+1 cycles. For 8-bit operands, N ≤ 257 (255,1).
- out_valid holds, with res stable, until out_ready. The handshake completes at that edge and in_ready is 1 in the following cycle.
- in_valid while busy is ignored; operands must be stable only during the accepting cycle.
- Reset asserted mid-CALC or mid-DONE: next cycle IDLE, out_valid=0, job discarded, cycles cleared.

## Configuration
- GCD_CTRL_CYCLE_CNT_EN defined:
  - cycles port and counter present.
  - Counter cleared on load handshake; +1 each CALC cycle including the beq0 cycle; saturates at all-ones.
  - Holds its value through DONE and IDLE until the next load.
- GCD_CTRL_CYCLE_CNT_EN undefined: no counter logic and no cycles port. All other behaviour is identical.

## Test plan
- (48,18) → swap/subtract sequence, res=6, out_valid 10 cycles after handshake, cycles=9.
- (0,0) → CALC 1 cycle, res=0, cycles=1. (7,0) → res=7, cycles=1. (0,7) → one swap, res=7, cycles=2.
- (255,1) → 255 subtracts, 1 swap, res=1, cycles=257 (saturate check with CNT_W=8 → 255).
- Hold out_ready=0 for 20 cycles in DONE → out_valid, res stable, en_a=en_b=0, in_valid ignored; release → IDLE next cycle, back-to-back job (12,8) → res=4.
- rst_n low during CALC of (200,3) → IDLE next cycle, out_valid=0, cycles=0; new job (9,6) → res=3.

Source files
------------

// File: rtl/gcd_ctrl.sv
// ============================================================================
// Module   : gcd_ctrl
// Purpose  : Control FSM for the subtractive GCD datapath. Accepts an operand
//            pair over a valid/ready handshake, steers the datapath muxes and
//            register enables until breg reaches zero, then presents the
//            datapath's registered result over a valid/ready handshake.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid / in_ready   - operand handshake (operands on datapath)
//            out_valid / out_ready - result handshake (result in datapath res)
//            busy                  - any state other than IDLE
//            beq0, agtb            - datapath status flags (breg==0, areg>=breg)
//            sel_a, sel_b          - datapath mux selects
//            en_a, en_b            - datapath register enables
//            cycles                - CALC-cycle count (optional feature only)
// Options  : GCD_CTRL_CYCLE_CNT_EN - adds the CNT_W parameter, the cycles port
//            and the saturating CALC-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_ctrl
`ifdef GCD_CTRL_CYCLE_CNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  input  logic             beq0,
  input  logic             agtb,
`ifdef GCD_CTRL_CYCLE_CNT_EN
  output logic [CNT_W-1:0] cycles,
`endif
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             en_a,
  output logic             en_b
);

  // Mux select codes
  localparam logic [1:0] c_SEL_A_LOAD = 2'b00;
  localparam logic [1:0] c_SEL_A_SUB  = 2'b01;
  localparam logic [1:0] c_SEL_A_B    = 2'b10;
  localparam logic [1:0] c_SEL_B_LOAD = 2'b00;
  localparam logic [1:0] c_SEL_B_A    = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs depend only on state, in_valid and the datapath flags; out_ready
  // only steers the next state so it never reaches the datapath controls.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sel_a     = c_SEL_A_LOAD;
    sel_b     = c_SEL_B_LOAD;
    en_a      = 1'b0;
    en_b      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Load both operands in the accepting cycle.
          en_a   = 1'b1;
          en_b   = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (beq0) begin
          // The datapath captures areg into res at this edge.
          w_next = S_DONE;
        end else if (agtb) begin
          sel_a = c_SEL_A_SUB;
          en_a  = 1'b1;
        end else begin
          // Swap: areg <= breg, breg <= areg.
          sel_a = c_SEL_A_B;
          sel_b = c_SEL_B_A;
          en_a  = 1'b1;
          en_b  = 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

`ifdef GCD_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycles;

  // Cleared on the load handshake, counts every CALC cycle (including the
  // terminating beq0 cycle), saturates, and holds through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_cycles <= '0;
    end else if ((r_state == S_CALC) && (r_cycles != {CNT_W{1'b1}})) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  assign cycles = r_cycles;
`endif

endmodule

`default_nettype wire
